vect_loader: RTL
================

# vect_loader

Upstream front-end of the BFP dot-product pipeline: accepts FP32 words one per cycle over a valid/ready stream, packs V of them into a vector, and presents that vector to the vector transposer with `vector_rdy` held until the transposer signals `done`. It replaces the bench-driven `vector`/`vector_rdy` pair with a real handshake.

## Interface
- `V`, 8, lanes per vector.
- `BIT`, 32, word width (IEEE-754 single).
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  upstream word valid.
- `in_ready`  out  1  loader can accept a word this cycle.
- `in_data`  in  BIT  FP32 word.
- `in_last`  in  1  qualifies `in_data` as the final word of a short vector.
- `vector`  out  [V-1:0][BIT-1:0]  packed vector, lane 0 = first accepted word.
- `vector_rdy`  out  1  `vector` complete and stable.
- `done`  in  1  transposer has consumed `vector`.
- `short_pkt`  out  1  one-cycle pulse: the vector just completed was terminated early by `in_last`.
- `vec_count`  out  16  number of vectors released to the transposer, wraps modulo 2^16.

## Operation
- States: FILL, HOLD. Reset state is FILL.
- Lane index `idx` is `$clog2(V)` bits wide and is 0 on entry to FILL.
- FILL:
  - `in_ready = 1` (forced 0 while `reset` is high).
  - On accept (`in_valid && in_ready`), write `vector[idx] <= in_data` and increment `idx`.
  - Go to HOLD if `idx == V-1`, or if `in_last` is 1.
  - If `in_last` is 1 and `idx < V-1`:
    - Lanes `idx+1..V-1` are written 0 on the same edge.
    - `short_pkt` pulses on the edge that enters HOLD.
  - `in_last` on lane V-1 is a normal completion with no `short_pkt`.
  - Without `in_last`, the V-th accepted word ends the vector. `in_last` is never required.
  - `done` is ignored in FILL.
- HOLD:
  - `in_ready = 0`, `vector_rdy = 1`, `vector` frozen.
  - On the first cycle `done == 1`: next state is FILL, `idx <= 0`, `vector_rdy <= 0`, `vec_count <= vec_count + 1`.
  - `done` may be a pulse or a level. Only its sampled value in HOLD matters.
  - `vector` keeps its contents after leaving HOLD until each lane is overwritten.
- Reset mid-operation: any partial vector is discarded and all outputs return to reset values on that edge.

## Timing
- Reset values: `vector` all 0, `vector_rdy` 0, `short_pkt` 0, `vec_count` 0, state FILL, `idx` 0. `in_ready` is 0 while `reset` is high and 1 on the first cycle after release.
- `vector_rdy`, `short_pkt`, `vector` and `vec_count` are registered.
- `in_ready` is a combinational decode of the registered state and `reset`. It has no dependence on `in_valid`.
- Latency: if the last lane is accepted at edge N, `vector_rdy` is 1 from edge N to the edge after `done` is sampled high.
- Best-case throughput is one vector per V+1 cycles: V accept cycles, plus 1 HOLD cycle with `done` high.
- A word presented while `in_ready = 0` is not consumed. Upstream must hold it.
- `done` high on the same edge as the final-word accept is ignored, because the loader is still in FILL. `vector_rdy` still rises.

## Configuration
- `VECT_LOADER_DENORM_FLUSH_EN` defined:
  - Any accepted word with exponent field `in_data[BIT-2:BIT-9] == 0` is stored as signed zero (`{in_data[BIT-1], {BIT-1{1'b0}}}`).
  - Purpose: the exponent-alignment and mantissa stages assume an implicit leading 1.
- Undefined: words are stored verbatim.
- Zero-fill lanes written by a short vector are 0 in both builds.

## Test plan
- Full vector:
  - Stimulus: after reset, stream 0x3FC00000, 0x40200000, 0x40600000, 0x40900000, then the same four again, with `in_valid` held high and `done` low.
  - Required: `vector_rdy` is 1 one edge after the 8th accept; lanes match the input order; `in_ready` is 0; `short_pkt` is 0.
- Hold and release:
  - Stimulus: in HOLD, hold `done` low for 5 cycles, then pulse it for 1 cycle.
  - Required: `vector` is stable throughout; `vector_rdy` falls and `vec_count` goes to 1 on the pulse edge; `in_ready` is 1 the next cycle.
- Short vector:
  - Stimulus: send 3 words (0x3FC00000, 0x40200000, 0x40600000), with `in_last` set on the third.
  - Required: lanes 3..7 are 0; `short_pkt` is a single 1-cycle pulse coincident with `vector_rdy` rising.
- Backpressure and bubbles:
  - Stimulus: `in_valid` toggles every cycle, and an extra word is presented during HOLD.
  - Required: only valid words are packed; the HOLD word is not consumed and lands in lane 0 of the next vector.
- Reset mid-fill:
  - Stimulus: assert `reset` after 5 accepted words.
  - Required: all outputs return to reset values; the next 8 words form a clean vector starting at lane 0.
- Denormal flush:
  - Stimulus: send 0x80000001 in lane 2.
  - Required: with `VECT_LOADER_DENORM_FLUSH_EN`, lane 2 = 0x80000000; without it, lane 2 = 0x80000001.

Source files
------------

// File: rtl/vect_loader.sv
// Packs V FP32 words from a valid/ready stream into one vector and holds it for the transposer until done.
// Optional build macro: VECT_LOADER_DENORM_FLUSH_EN flushes zero-exponent words to signed zero on capture.
module vect_loader #(
    parameter int unsigned V   = 8,
    parameter int unsigned BIT = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BIT-1:0]          in_data,
    input  logic                    in_last,
    output logic [V-1:0][BIT-1:0]   vector,
    output logic                    vector_rdy,
    input  logic                    done,
    output logic                    short_pkt,
    output logic [15:0]             vec_count
);

    localparam int unsigned IDX_W = (V > 1) ? $clog2(V) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(V - 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                 state, state_d;
    logic [IDX_W-1:0]       idx, idx_d;
    logic [V-1:0][BIT-1:0]  vector_d;
    logic                   vector_rdy_d;
    logic                   short_pkt_d;
    logic [15:0]            vec_count_d;
    logic [BIT-1:0]         word_c;
    logic                   accept_c;

    assign in_ready = (state == FILL) && !reset;
    assign accept_c = in_valid && in_ready;

    // Word as it will be stored in its lane
    always_comb begin
        word_c = in_data;
`ifdef VECT_LOADER_DENORM_FLUSH_EN
        if (in_data[BIT-2 -: 8] == 8'd0) begin
            word_c = {in_data[BIT-1], (BIT-1)'(0)};
        end
`endif
    end

    // Next-state and output decode
    always_comb begin
        state_d      = state;
        idx_d        = idx;
        vector_d     = vector;
        vector_rdy_d = vector_rdy;
        short_pkt_d  = 1'b0;
        vec_count_d  = vec_count;

        case (state)
            FILL: begin
                if (accept_c) begin
                    vector_d[idx] = word_c;
                    idx_d         = idx + IDX_W'(1);
                    if ((idx == LAST_IDX) || in_last) begin
                        state_d      = HOLD;
                        vector_rdy_d = 1'b1;
                        short_pkt_d  = in_last && (idx != LAST_IDX);
                        // A short vector zero-fills every lane above the final word
                        if (in_last) begin
                            for (int unsigned i = 0; i < V; i++) begin
                                if (i > 32'(idx)) begin
                                    vector_d[i] = '0;
                                end
                            end
                        end
                    end
                end
            end
            HOLD: begin
                if (done) begin
                    state_d      = FILL;
                    idx_d        = '0;
                    vector_rdy_d = 1'b0;
                    vec_count_d  = vec_count + 16'd1;
                end
            end
            default: begin
                state_d = FILL;
                idx_d   = '0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FILL;
            idx        <= '0;
            vector     <= '0;
            vector_rdy <= 1'b0;
            short_pkt  <= 1'b0;
            vec_count  <= 16'd0;
        end else begin
            state      <= state_d;
            idx        <= idx_d;
            vector     <= vector_d;
            vector_rdy <= vector_rdy_d;
            short_pkt  <= short_pkt_d;
            vec_count  <= vec_count_d;
        end
    end

endmodule
